// File: rtl/stream_xbar_arbiter_pkg.sv
// Shared types and width helpers for the stream crossbar arbiter.
package xbar_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

   // A single-entry side still needs one bit to carry an index.
   function automatic int id_width(input int s_count);
      return (s_count > 1) ? $clog2(s_count) : 1;
   endfunction

   function automatic int dest_width(input int m_count);
      return (m_count > 1) ? $clog2(m_count) : 1;
   endfunction

endpackage

// File: rtl/stream_xbar_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import xbar_pkg::*;
#(
   parameter int  S_DATA_COUNT = 2,
   localparam int T_ID___WIDTH = id_width(S_DATA_COUNT)
) (
   input  logic [S_DATA_COUNT-1:0] req,
   input  logic [T_ID___WIDTH-1:0] ptr,
   output logic [T_ID___WIDTH-1:0] idx,
   output logic                    found
);

   // Outer loop walks the rotated search order, inner loop keeps indexing constant.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < S_DATA_COUNT; k++) begin
         for (int j = 0; j < S_DATA_COUNT; j++) begin
            if (!found && req[j] && (j == ((int'(ptr) + k) % S_DATA_COUNT))) begin
               found = 1'b1;
               idx   = j[T_ID___WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/stream_xbar_arbiter.sv
// Per-output round-robin arbiter that locks a source to an output for a whole packet.
module stream_xbar_arbiter
   import xbar_pkg::*;
#(
   parameter int  S_DATA_COUNT = 2,
   parameter int  M_DATA_COUNT = 3,
   localparam int T_ID___WIDTH = id_width(S_DATA_COUNT),
   localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_in,
   input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
   input  logic [S_DATA_COUNT-1:0]              s_last_i,
   input  logic [S_DATA_COUNT-1:0]              s_valid_i,
   output logic [S_DATA_COUNT-1:0]              s_ready_o,
   input  logic [M_DATA_COUNT-1:0]              m_valid_i,
   input  logic [M_DATA_COUNT-1:0]              m_ready_i,
   output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] grant_o,
   output logic [M_DATA_COUNT-1:0]              arbiter_ready_o,
   output logic [M_DATA_COUNT-1:0]              busy_o
);

   logic [M_DATA_COUNT-1:0]                 locked;
   logic [M_DATA_COUNT-1:0]                 arb_ready;
   logic [M_DATA_COUNT*T_ID___WIDTH-1:0]    grant_all;
   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
   logic [S_DATA_COUNT-1:0]                 locked_any;
   logic [S_DATA_COUNT-1:0]                 s_ready;

   always_comb begin
      locked_any = '0;
      for (int i = 0; i < M_DATA_COUNT; i++) begin
         for (int j = 0; j < S_DATA_COUNT; j++) begin
            if (locked[i] && (grant_all[i*T_ID___WIDTH +: T_ID___WIDTH] == j[T_ID___WIDTH-1:0]))
               locked_any[j] = 1'b1;
         end
      end
   end

   // Out-of-range destinations match no channel index, so they never request.
   always_comb begin
      req = '0;
      for (int i = 0; i < M_DATA_COUNT; i++) begin
         for (int j = 0; j < S_DATA_COUNT; j++) begin
            req[i][j] = s_valid_i[j] && !locked_any[j] &&
                        (s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH] == i[T_DEST_WIDTH-1:0]);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < M_DATA_COUNT; i++)
         arb_ready[i] = locked[i] && (!m_valid_i[i] || m_ready_i[i]);
   end

   // Each source targets one output, so at most one channel drives each ready bit.
   always_comb begin
      s_ready = '0;
      for (int i = 0; i < M_DATA_COUNT; i++) begin
         for (int j = 0; j < S_DATA_COUNT; j++) begin
            if (arb_ready[i] && (grant_all[i*T_ID___WIDTH +: T_ID___WIDTH] == j[T_ID___WIDTH-1:0]))
               s_ready[j] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < M_DATA_COUNT; g++) begin : gen_chan
      arb_state_e              state;
      logic [T_ID___WIDTH-1:0] ptr;
      logic [T_ID___WIDTH-1:0] grant;
      logic [T_ID___WIDTH-1:0] pick;
      logic                    found;
      logic                    release_pkt;

      rr_arbiter #(
         .S_DATA_COUNT(S_DATA_COUNT)
      ) u_rr (
         .req  (req[g]),
         .ptr  (ptr),
         .idx  (pick),
         .found(found)
      );

      assign release_pkt = arb_ready[g] && s_valid_i[grant] && s_last_i[grant];

      always_ff @(posedge clk_i) begin
         if (!rst_in) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            grant <= '0;
         end else if (state == ARB_IDLE) begin
            if (found) begin
               grant <= pick;
               ptr   <= (pick == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : pick + 1'b1;
               state <= ARB_LOCKED;
            end
         end else if (release_pkt) begin
            state <= ARB_IDLE;
         end
      end

      assign locked[g]                                   = (state == ARB_LOCKED);
      assign grant_all[g*T_ID___WIDTH +: T_ID___WIDTH]   = grant;
   end

   assign s_ready_o       = s_ready;
   assign grant_o         = grant_all;
   assign arbiter_ready_o = arb_ready;
   assign busy_o          = locked;

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// Directed bench for stream_xbar_arbiter with S=2 sources and M=3 outputs.
module tb_stream_xbar_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] s_dest;
   logic [1:0] s_last;
   logic [1:0] s_valid;
   logic [1:0] s_ready;
   logic [2:0] m_valid;
   logic [2:0] m_ready;
   logic [2:0] grant;
   logic [2:0] arb_ready;
   logic [2:0] busy;

   int tests = 0;
   int fails = 0;

   // Contention expectations, one entry per cycle starting with the request cycle.
   logic       exp_busy [12] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
   logic       exp_gnt  [12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
   logic [1:0] exp_rdy  [12] = '{2'b00,2'b01,2'b01,2'b00,2'b10,2'b10,2'b00,2'b01,2'b01,2'b00,2'b10,2'b10};

   always #5 clk = ~clk;

   stream_xbar_arbiter #(
      .S_DATA_COUNT(2),
      .M_DATA_COUNT(3)
   ) dut (
      .clk_i          (clk),
      .rst_in         (rst_n),
      .s_dest_i       (s_dest),
      .s_last_i       (s_last),
      .s_valid_i      (s_valid),
      .s_ready_o      (s_ready),
      .m_valid_i      (m_valid),
      .m_ready_i      (m_ready),
      .grant_o        (grant),
      .arbiter_ready_o(arb_ready),
      .busy_o         (busy)
   );

   task automatic idle_inputs();
      s_valid = 2'b00;
      s_last  = 2'b00;
      s_dest  = 4'h0;
      m_valid = 3'b000;
      m_ready = 3'b111;
   endtask

   // Leaves the bench at a falling edge with reset released and no rising edge yet.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      s_valid = 2'b11;
      s_last  = 2'b00;
      s_dest  = {2'd1, 2'd0};
      m_valid = 3'b000;
      m_ready = 3'b000;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL reset_s_ready: got %b want %b", s_ready, 2'b00); end
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b want %b", busy, 3'b000); end
      tests++; if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant: got %b want %b", grant, 3'b000); end
      tests++; if (arb_ready !== 3'b000) begin fails++; $display("FAIL reset_arb_ready: got %b want %b", arb_ready, 3'b000); end
      rst_n = 1'b1;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL release_before_edge_busy: got %b want %b", busy, 3'b000); end
      @(negedge clk);
      #1;
      tests++; if (busy !== 3'b011) begin fails++; $display("FAIL release_busy: got %b want %b", busy, 3'b011); end
      tests++; if (grant !== 3'b010) begin fails++; $display("FAIL release_grant: got %b want %b", grant, 3'b010); end
      tests++; if (s_ready !== 2'b11) begin fails++; $display("FAIL release_s_ready: got %b want %b", s_ready, 2'b11); end
      tests++; if (arb_ready !== 3'b011) begin fails++; $display("FAIL release_arb_ready: got %b want %b", arb_ready, 3'b011); end
      // Reset mid-packet must drop both locks.
      @(negedge clk);
      rst_n   = 1'b0;
      s_valid = 2'b00;
      @(negedge clk);
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL reset_midpkt_busy: got %b want %b", busy, 3'b000); end
      tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL reset_midpkt_s_ready: got %b want %b", s_ready, 2'b00); end
   endtask

   task automatic test_single_source();
      do_reset();
      s_dest  = {2'd0, 2'd2};
      s_valid = 2'b01;
      s_last  = 2'b00;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL single_req_busy: got %b want %b", busy, 3'b000); end
      tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL single_req_s_ready: got %b want %b", s_ready, 2'b00); end
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
         s_last[0] = (b == 2);
         #1;
         tests++; if (busy !== 3'b100) begin fails++; $display("FAIL single_busy_beat%0d: got %b want %b", b, busy, 3'b100); end
         tests++; if (grant[2] !== 1'b0) begin fails++; $display("FAIL single_grant_beat%0d: got %b want %b", b, grant[2], 1'b0); end
         tests++; if (s_ready !== 2'b01) begin fails++; $display("FAIL single_s_ready_beat%0d: got %b want %b", b, s_ready, 2'b01); end
         @(negedge clk);
      end
      s_valid = 2'b00;
      s_last  = 2'b00;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL single_release_busy: got %b want %b", busy, 3'b000); end
      tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL single_release_s_ready: got %b want %b", s_ready, 2'b00); end
   endtask

   task automatic test_contention();
      int         cnt [2];
      logic [1:0] acc;
      do_reset();
      cnt[0]  = 0;
      cnt[1]  = 0;
      s_dest  = {2'd1, 2'd1};
      s_valid = 2'b11;
      for (int c = 0; c < 12; c++) begin
         s_last[0] = (cnt[0] == 1);
         s_last[1] = (cnt[1] == 1);
         #1;
         tests++; if (busy[1] !== exp_busy[c]) begin fails++; $display("FAIL contention_busy_c%0d: got %b want %b", c, busy[1], exp_busy[c]); end
         tests++; if (s_ready !== exp_rdy[c]) begin fails++; $display("FAIL contention_s_ready_c%0d: got %b want %b", c, s_ready, exp_rdy[c]); end
         if (exp_busy[c]) begin
            tests++; if (grant[1] !== exp_gnt[c]) begin fails++; $display("FAIL contention_grant_c%0d: got %b want %b", c, grant[1], exp_gnt[c]); end
         end
         acc = s_valid & s_ready;
         @(negedge clk);
         for (int j = 0; j < 2; j++)
            if (acc[j]) cnt[j] = s_last[j] ? 0 : cnt[j] + 1;
      end
      s_valid = 2'b00;
      s_last  = 2'b00;
   endtask

   task automatic test_backpressure();
      do_reset();
      s_dest  = {2'd0, 2'd0};
      s_valid = 2'b01;
      s_last  = 2'b00;
      m_valid = 3'b001;
      m_ready = 3'b001;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL bp_req_busy: got %b want %b", busy, 3'b000); end
      @(negedge clk);
      #1;
      tests++; if (s_ready !== 2'b01) begin fails++; $display("FAIL bp_first_s_ready: got %b want %b", s_ready, 2'b01); end
      tests++; if (arb_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_first_arb_ready: got %b want %b", arb_ready[0], 1'b1); end
      @(negedge clk);
      m_ready = 3'b000;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests++; if (arb_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_stall_arb_ready_c%0d: got %b want %b", c, arb_ready[0], 1'b0); end
         tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL bp_stall_s_ready_c%0d: got %b want %b", c, s_ready, 2'b00); end
         tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL bp_stall_busy_c%0d: got %b want %b", c, busy[0], 1'b1); end
         @(negedge clk);
      end
      // Empty output slot: a bubble load is permitted even with downstream not ready.
      m_valid = 3'b000;
      s_valid = 2'b00;
      #1;
      tests++; if (arb_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_free_slot_arb_ready: got %b want %b", arb_ready[0], 1'b1); end
      tests++; if (s_ready !== 2'b01) begin fails++; $display("FAIL bp_free_slot_s_ready: got %b want %b", s_ready, 2'b01); end
      @(negedge clk);
      m_valid = 3'b001;
      m_ready = 3'b001;
      s_valid = 2'b01;
      s_last  = 2'b01;
      #1;
      tests++; if (s_ready !== 2'b01) begin fails++; $display("FAIL bp_resume_s_ready: got %b want %b", s_ready, 2'b01); end
      tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL bp_resume_busy: got %b want %b", busy[0], 1'b1); end
      @(negedge clk);
      s_valid = 2'b00;
      s_last  = 2'b00;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL bp_release_busy: got %b want %b", busy, 3'b000); end
   endtask

   task automatic test_parallel();
      do_reset();
      s_dest  = {2'd2, 2'd0};
      s_valid = 2'b11;
      s_last  = 2'b00;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL par_req_busy: got %b want %b", busy, 3'b000); end
      @(negedge clk);
      #1;
      tests++; if (busy !== 3'b101) begin fails++; $display("FAIL par_busy: got %b want %b", busy, 3'b101); end
      tests++; if (grant !== 3'b100) begin fails++; $display("FAIL par_grant: got %b want %b", grant, 3'b100); end
      tests++; if (s_ready !== 2'b11) begin fails++; $display("FAIL par_s_ready: got %b want %b", s_ready, 2'b11); end
      tests++; if (arb_ready !== 3'b101) begin fails++; $display("FAIL par_arb_ready: got %b want %b", arb_ready, 3'b101); end
      @(negedge clk);
      s_last = 2'b11;
      #1;
      tests++; if (busy !== 3'b101) begin fails++; $display("FAIL par_last_busy: got %b want %b", busy, 3'b101); end
      tests++; if (s_ready !== 2'b11) begin fails++; $display("FAIL par_last_s_ready: got %b want %b", s_ready, 2'b11); end
      @(negedge clk);
      s_valid = 2'b00;
      s_last  = 2'b00;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL par_release_busy: got %b want %b", busy, 3'b000); end
   endtask

   task automatic test_out_of_range();
      do_reset();
      s_dest  = {2'd3, 2'd1};
      s_valid = 2'b11;
      s_last  = 2'b01;
      #1;
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL oor_req_busy: got %b want %b", busy, 3'b000); end
      tests++; if (s_ready !== 2'b00) begin fails++; $display("FAIL oor_req_s_ready: got %b want %b", s_ready, 2'b00); end
      @(negedge clk);
      #1;
      tests++; if (busy !== 3'b010) begin fails++; $display("FAIL oor_single_beat_busy: got %b want %b", busy, 3'b010); end
      tests++; if (grant !== 3'b000) begin fails++; $display("FAIL oor_single_beat_grant: got %b want %b", grant, 3'b000); end
      tests++; if (s_ready !== 2'b01) begin fails++; $display("FAIL oor_single_beat_s_ready: got %b want %b", s_ready, 2'b01); end
      @(negedge clk);
      s_valid = 2'b10;
      s_last  = 2'b00;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests++; if (busy !== 3'b000) begin fails++; $display("FAIL oor_busy_c%0d: got %b want %b", c, busy, 3'b000); end
         tests++; if (s_ready[1] !== 1'b0) begin fails++; $display("FAIL oor_s_ready_c%0d: got %b want %b", c, s_ready[1], 1'b0); end
         tests++; if (grant !== 3'b000) begin fails++; $display("FAIL oor_grant_c%0d: got %b want %b", c, grant, 3'b000); end
         @(negedge clk);
      end
      s_valid = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_source();
      test_contention();
      test_backpressure();
      test_parallel();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
